// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_btb
// Description : Direct-mapped saturating-counter direction predictor combined
//               with a tagged branch target buffer. Looked up combinationally
//               in IF with the fetch PC, trained from ID with the resolved
//               outcome and target.
//
//               Optional macro BP_GSHARE_EN: counters are indexed with the
//               PC index XOR a global history register (gshare); tag, valid
//               and target arrays stay PC-indexed.
//
// Ports       : clk          - clock, all state changes on rising edge
//               srst         - synchronous reset, active-high
//               en           - global enable for training
//               lookup_pc    - fetch PC
//               pred_hit     - valid entry with matching tag
//               pred_taken   - predicted taken
//               pred_target  - predicted next PC
//               pred_ghr     - history snapshot for this lookup (0 w/o gshare)
//               upd_valid    - training request
//               upd_pc       - PC of the resolved branch
//               upd_taken    - resolved direction
//               upd_target   - resolved target
//               upd_ghr      - pred_ghr captured at lookup
//
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_btb #(
    parameter int ADDR_W  = 64,
    parameter int ENTRIES = 32,
    parameter int IDX_LSB = 2,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic [IDX_W-1:0]  pred_ghr,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic [IDX_W-1:0]  upd_ghr
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_wt  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] c_cnt_wnt = c_cnt_wt - CNT_W'(1);

    // ------------------------------------------------------------------
    // Table state
    // ------------------------------------------------------------------
    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0] r_target [ENTRIES];
    logic [CNT_W-1:0]  r_cnt    [ENTRIES];

    // ------------------------------------------------------------------
    // Index / tag extraction
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_li;     // lookup index into tag/valid/target
    logic [IDX_W-1:0] w_lci;    // lookup index into counters
    logic [TAG_W-1:0] w_ltag;
    logic [IDX_W-1:0] w_ui;     // update index into tag/valid/target
    logic [IDX_W-1:0] w_uci;    // update index into counters
    logic [TAG_W-1:0] w_utag;

    assign w_li   = lookup_pc[IDX_LSB +: IDX_W];
    assign w_ltag = lookup_pc[IDX_LSB + IDX_W +: TAG_W];
    assign w_ui   = upd_pc[IDX_LSB +: IDX_W];
    assign w_utag = upd_pc[IDX_LSB + IDX_W +: TAG_W];

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    assign w_lci    = w_li ^ r_ghr;
    // The history used at prediction time travels with the branch so the
    // same counter is trained even though r_ghr has moved on since.
    assign w_uci    = w_ui ^ upd_ghr;
    assign pred_ghr = r_ghr;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_ghr <= '0;
        end else if (en && upd_valid) begin
            r_ghr <= {r_ghr[IDX_W-2:0], upd_taken};
        end
    end
`else
    assign w_lci    = w_li;
    assign w_uci    = w_ui;
    assign pred_ghr = '0;
`endif

    // Bits outside the index/tag fields, and upd_ghr in PC-only mode, are
    // intentionally ignored.
    logic w_unused;
    assign w_unused = &{1'b0, lookup_pc, upd_pc, upd_ghr};

    // ------------------------------------------------------------------
    // Lookup: purely combinational from registered state (no bypass of a
    // same-cycle update)
    // ------------------------------------------------------------------
    always_comb begin
        pred_hit    = r_valid[w_li] && (r_tag[w_li] == w_ltag);
        pred_taken  = pred_hit && r_cnt[w_lci][CNT_W-1];
        pred_target = pred_taken ? r_target[w_li] : (lookup_pc + ADDR_W'(4));
    end

    // ------------------------------------------------------------------
    // Training
    // ------------------------------------------------------------------
    logic             w_uhit;
    logic [CNT_W-1:0] w_cnt_cur;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_dec;

    always_comb begin
        w_uhit    = r_valid[w_ui] && (r_tag[w_ui] == w_utag);
        w_cnt_cur = r_cnt[w_uci];
        w_cnt_inc = (w_cnt_cur == c_cnt_max) ? c_cnt_max : (w_cnt_cur + CNT_W'(1));
        w_cnt_dec = (w_cnt_cur == '0)        ? '0        : (w_cnt_cur - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                r_valid[k]  <= 1'b0;
                r_tag[k]    <= '0;
                r_target[k] <= '0;
                r_cnt[k]    <= c_cnt_wnt;
            end
        end else if (en && upd_valid) begin
            if (w_uhit) begin
                if (upd_taken) begin
                    r_cnt[w_uci]   <= w_cnt_inc;
                    r_target[w_ui] <= upd_target;
                end else begin
                    r_cnt[w_uci]   <= w_cnt_dec;
                end
            end else if (upd_taken) begin
                // Only taken branches earn a BTB slot; the new entry starts
                // weakly taken so a single later not-taken flips it.
                r_valid[w_ui]  <= 1'b1;
                r_tag[w_ui]    <= w_utag;
                r_target[w_ui] <= upd_target;
                r_cnt[w_uci]   <= c_cnt_wt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor_btb
// Description : Self-checking bench for branch_predictor_btb. Directed
//               scenarios with literal expectations plus a randomized phase
//               compared every cycle against a behavioural table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_btb;

    localparam int ADDR_W  = 64;
    localparam int ENTRIES = 32;
    localparam int IDX_LSB = 2;
    localparam int TAG_W   = 8;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = 5;

    logic              clk = 1'b0;
    logic              srst;
    logic              en;
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic [IDX_W-1:0]  pred_ghr;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic [IDX_W-1:0]  upd_ghr;

    int n_checks = 0;
    int n_fails  = 0;

    branch_predictor_btb #(
        .ADDR_W (ADDR_W),
        .ENTRIES(ENTRIES),
        .IDX_LSB(IDX_LSB),
        .TAG_W  (TAG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .en         (en),
        .lookup_pc  (lookup_pc),
        .pred_hit   (pred_hit),
        .pred_taken (pred_taken),
        .pred_target(pred_target),
        .pred_ghr   (pred_ghr),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .upd_ghr    (upd_ghr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a table described by arithmetic on the PC
    // ------------------------------------------------------------------
    bit          m_ready = 1'b0;
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [63:0] m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    int          m_ghr;
    bit          gshare;

    initial begin
`ifdef BP_GSHARE_EN
        gshare = 1'b1;
`else
        gshare = 1'b0;
`endif
    end

    function automatic int fidx(input logic [63:0] pc);
        return int'((pc >> IDX_LSB) % ENTRIES);
    endfunction

    function automatic int unsigned ftag(input logic [63:0] pc);
        return int'((pc >> (IDX_LSB + IDX_W)) % (64'd1 << TAG_W));
    endfunction

    always @(posedge clk) begin
        if (srst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k]  = 1'b0;
                m_tag[k]    = 0;
                m_target[k] = '0;
                m_cnt[k]    = (1 << (CNT_W - 1)) - 1;
            end
            m_ghr   = 0;
            m_ready = 1'b1;
        end else if (en && upd_valid) begin
            int i, ci;
            i  = fidx(upd_pc);
            ci = gshare ? (i ^ int'(upd_ghr)) : i;
            if (m_valid[i] && m_tag[i] == ftag(upd_pc)) begin
                if (upd_taken) begin
                    if (m_cnt[ci] < (1 << CNT_W) - 1) m_cnt[ci] = m_cnt[ci] + 1;
                    m_target[i] = upd_target;
                end else if (m_cnt[ci] > 0) begin
                    m_cnt[ci] = m_cnt[ci] - 1;
                end
            end else if (upd_taken) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = ftag(upd_pc);
                m_target[i] = upd_target;
                m_cnt[ci]   = 1 << (CNT_W - 1);
            end
            if (gshare) m_ghr = ((m_ghr << 1) | int'(upd_taken)) % ENTRIES;
        end
    end

    // Every-cycle comparison of the lookup outputs against the model.
    always @(negedge clk) begin
        if (m_ready) begin
            int i, ci;
            bit e_hit, e_taken;
            logic [63:0] e_tgt;
            i       = fidx(lookup_pc);
            ci      = gshare ? (i ^ m_ghr) : i;
            e_hit   = m_valid[i] && (m_tag[i] == ftag(lookup_pc));
            e_taken = e_hit && (m_cnt[ci] >= (1 << (CNT_W - 1)));
            e_tgt   = e_taken ? m_target[i] : lookup_pc + 64'd4;
            chk("model_hit",    64'(pred_hit),   64'(e_hit));
            chk("model_taken",  64'(pred_taken), 64'(e_taken));
            chk("model_target", pred_target,     e_tgt);
            chk("model_ghr",    64'(pred_ghr),   64'(gshare ? m_ghr : 0));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input bit s, input bit e, input logic [63:0] lpc,
                         input bit uv, input logic [63:0] upc, input bit ut,
                         input logic [63:0] utg, input logic [IDX_W-1:0] ug);
        @(posedge clk);
        #1;
        srst = s; en = e; lookup_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg; upd_ghr = ug;
        #2;
    endtask

    task automatic look(input logic [63:0] lpc);
        drive(1'b0, 1'b1, lpc, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, '0, 1'b0, '0, 1'b0, '0, '0);
        drive(1'b1, 1'b1, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    function automatic logic [63:0] rpc();
        logic [63:0] p;
        p = 64'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) p = {$urandom, $urandom};
        if ($urandom_range(0, 31) == 0) p = 64'hFFFF_FFFF_FFFF_FFFC;
        return p;
    endfunction

    initial begin
        srst = 1'b1; en = 1'b1; lookup_pc = '0; upd_valid = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_ghr = '0;

        // Reset state
        do_reset();
        look(64'h100);
        chk("rst_hit",    64'(pred_hit),   64'd0);
        chk("rst_taken",  64'(pred_taken), 64'd0);
        chk("rst_target", pred_target,     64'h104);
        chk("rst_ghr",    64'(pred_ghr),   64'd0);
        look(64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_target", pred_target, 64'h0);

`ifndef BP_GSHARE_EN
        begin
            bit dirs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            bit exps [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            // First training, lookup same cycle sees pre-update state
            drive(1'b0, 1'b1, 64'h100, 1'b1, 64'h100, 1'b1, 64'h80, '0);
            chk("same_cycle_hit", 64'(pred_hit), 64'd0);
            look(64'h100);
            chk("alloc_hit",    64'(pred_hit),   64'd1);
            chk("alloc_taken",  64'(pred_taken), 64'd1);
            chk("alloc_target", pred_target,     64'h80);
            // Counter walk N,N,N,T,T from weakly taken
            for (int k = 0; k < 5; k++) begin
                drive(1'b0, 1'b1, 64'h100, 1'b1, 64'h100, dirs[k], 64'h80, '0);
                look(64'h100);
                chk("walk_hit",   64'(pred_hit),   64'd1);
                chk("walk_taken", 64'(pred_taken), 64'(exps[k]));
            end
            // Alias: same index, different tag
            look(64'h180);
            chk("alias_hit",    64'(pred_hit), 64'd0);
            chk("alias_target", pred_target,   64'h184);
            drive(1'b0, 1'b1, 64'h0, 1'b1, 64'h180, 1'b1, 64'h40, '0);
            look(64'h100);
            chk("replaced_old_hit", 64'(pred_hit), 64'd0);
            look(64'h180);
            chk("replaced_new_hit",    64'(pred_hit), 64'd1);
            chk("replaced_new_target", pred_target,   64'h40);
            // en=0 drops updates
            do_reset();
            drive(1'b0, 1'b1, 64'h100, 1'b1, 64'h100, 1'b1, 64'h80, '0);
            drive(1'b0, 1'b0, 64'h100, 1'b1, 64'h200, 1'b1, 64'h44, '0);
            chk("en0_lookup_hit", 64'(pred_hit), 64'd1);
            look(64'h200);
            chk("en0_no_alloc", 64'(pred_hit), 64'd0);
            look(64'h100);
            chk("en0_kept", 64'(pred_hit), 64'd1);
            // srst beats a concurrent update
            drive(1'b1, 1'b1, 64'h0, 1'b1, 64'h300, 1'b1, 64'h44, '0);
            look(64'h300);
            chk("srst_upd_hit", 64'(pred_hit), 64'd0);
            look(64'h100);
            chk("srst_cleared", 64'(pred_hit), 64'd0);
        end
`else
        // History T,T,N -> 0b00110; counter of PC 0 read at index 6
        do_reset();
        drive(1'b0, 1'b1, 64'h0, 1'b1, 64'h000, 1'b1, 64'h500, 5'd6);
        drive(1'b0, 1'b1, 64'h0, 1'b1, 64'h004, 1'b1, 64'h600, 5'd0);
        drive(1'b0, 1'b1, 64'h0, 1'b1, 64'h008, 1'b0, 64'h700, 5'd0);
        look(64'h000);
        chk("gs_ghr",    64'(pred_ghr),   64'd6);
        chk("gs_hit",    64'(pred_hit),   64'd1);
        chk("gs_taken",  64'(pred_taken), 64'd1);
        chk("gs_target", pred_target,     64'h500);
`endif

        // Randomized phase against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, rpc(),
                  $urandom_range(0, 9) < 6, rpc(), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, IDX_W'($urandom));
        end
        look(64'h0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Parametrised successor to the 1-bit branch history table. Combines a direct-mapped table of saturating counters with a tagged branch target buffer. Sits in IF: it is looked up with the fetch PC and delivers a direction and a target in the same cycle. It is trained from ID with the resolved branch outcome and target. An optional global-history (gshare) index mode is available.

Parameters:
ADDR_W, 64, PC and target width.
ENTRIES, 32, table depth; power of 2, minimum 4. IDX_W = log2(ENTRIES).
IDX_LSB, 2, lowest PC bit used for the index; bits below it are ignored.
TAG_W, 8, tag width; tag = pc[IDX_LSB+IDX_W +: TAG_W].
CNT_W, 2, counter width, minimum 1.

Ports:
clk  in  1  clock; all state changes on the rising edge.
srst  in  1  synchronous reset, active-high.
en  in  1  global enable; when 0, no state changes.
lookup_pc  in  ADDR_W  fetch PC.
pred_hit  out  1  valid entry with matching tag.
pred_taken  out  1  predicted taken.
pred_target  out  ADDR_W  predicted next PC.
pred_ghr  out  IDX_W  history snapshot for this lookup; 0 when the macro is off.
upd_valid  in  1  training request, single cycle.
upd_pc  in  ADDR_W  PC of the resolved branch.
upd_taken  in  1  resolved direction.
upd_target  in  ADDR_W  resolved target.
upd_ghr  in  IDX_W  pred_ghr value captured at lookup; ignored when the macro is off.

Behaviour:
- State per entry: valid (1 bit), tag (TAG_W), target (ADDR_W), cnt (CNT_W). Plus ghr (IDX_W) when the macro is on.
- Lookup index: li = lookup_pc[IDX_LSB +: IDX_W]. Update index: ui = upd_pc[IDX_LSB +: IDX_W].
- Lookup is combinational from registered state, zero latency:
  - pred_hit = valid[li] & (tag[li] == lookup tag).
  - pred_taken = pred_hit & cnt[li][CNT_W-1].
  - pred_target = target[li] when pred_taken, else lookup_pc + 4 (modulo 2^ADDR_W).
- Update, applied on the clock edge when en & upd_valid:
  - Hit (valid and tag match):
    - taken: cnt saturating increment, capped at 2^CNT_W-1; target <= upd_target.
    - not taken: cnt saturating decrement, floored at 0; target unchanged.
  - Miss and taken: allocate/replace the entry: valid<=1, tag<=upd tag, target<=upd_target, cnt<=2^(CNT_W-1) (weakly taken).
  - Miss and not taken: no change.
- Lookup and update in the same cycle, same index: lookup returns pre-update state; no bypass.
- en=0: updates dropped, srst still honoured, lookup outputs remain valid.
- srst (also mid-operation; it overrides a concurrent update):
  - all valid<=0, cnt<=2^(CNT_W-1)-1 (weakly not taken), tag and target<=0, ghr<=0.
  - Resulting outputs: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4, pred_ghr=0.
- CNT_W=1 degenerates to a 1-bit last-outcome predictor with a BTB.

Optional Feature:
Macro BP_GSHARE_EN.
- Defined:
  - Lookup index = lookup_pc[IDX_LSB +: IDX_W] ^ ghr; pred_ghr = ghr.
  - Counter index on update = ui ^ upd_ghr.
  - Tag, target and valid arrays keep the pure-PC index ui.
  - On every en & upd_valid: ghr <= {ghr[IDX_W-2:0], upd_taken}.
- Not defined: no ghr register, PC-only indexing, pred_ghr tied to 0, upd_ghr unused.

Test Plan:
1. Assert srst 2 cycles, then lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, pred_ghr=0.
2. Update pc=0x100, taken, target=0x80; next cycle lookup 0x100 -> hit=1, taken=1 (cnt=2), target=0x80.
3. From test 2, apply N, N, N, T, T updates to 0x100 -> cnt goes 1, 0, 0 (saturates), 1, 2. pred_taken is 0 after the first N and returns to 1 after the second T.
4. Alias check: train 0x100 taken, then lookup 0x180 (same index 0, tag 3 vs 2) -> hit=0, target=0x184. Taken update for 0x180 (target 0x40) replaces the entry; lookup 0x100 now misses.
5. Same-cycle check: update 0x100 taken (first time) with lookup 0x100 in the same cycle -> hit=0 that cycle, hit=1 the next. An update with en=0 -> no change. srst together with upd_valid -> table stays empty.
6. BP_GSHARE_EN, reset, then updates T, T, N -> pred_ghr=0b00110. A lookup of 0x000 reads counter index 6, not 0.
